// File: rtl/pf_iod_dly_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pf_iod_dly_tap_ctrl
// Purpose  : Fabric-side controller for the PolarFire IOD dynamic delay line.
//            Converts an absolute tap request into a paced sequence of
//            single-tap MOVE pulses (or one LOAD pulse) and tracks the tap
//            position the IOD is believed to hold.
// Ports    : FAB_CLK, ARST                 - clock, async active-high reset
//            REQ_VALID/REQ_READY           - request handshake (ready in IDLE)
//            REQ_LOAD, REQ_TAP             - reload request / absolute target
//            DONE, ERR                     - completion pulse, error flag
//            CUR_TAP                       - tracked tap position
//            DELAY_LINE_MOVE/DIRECTION/LOAD- IOD delay-line controls
//            DELAY_LINE_OUT_OF_RANGE       - IOD range flag
// Revision : 1.0 - initial release
// ============================================================================
module pf_iod_dly_tap_ctrl #(
   parameter int TAP_W    = 8,
   parameter int MAX_TAP  = 127,
   parameter int LOAD_TAP = 1,
   parameter int MOVE_GAP = 2
) (
   input  logic             FAB_CLK,
   input  logic             ARST,
   input  logic             REQ_VALID,
   output logic             REQ_READY,
   input  logic             REQ_LOAD,
   input  logic [TAP_W-1:0] REQ_TAP,
   output logic             DONE,
   output logic             ERR,
   output logic [TAP_W-1:0] CUR_TAP,
   output logic             DELAY_LINE_MOVE,
   output logic             DELAY_LINE_DIRECTION,
   output logic             DELAY_LINE_LOAD,
   input  logic             DELAY_LINE_OUT_OF_RANGE
);

   localparam int                 GAP_W    = (MOVE_GAP > 1) ? $clog2(MOVE_GAP) : 1;
   localparam logic [GAP_W-1:0]   GAP_LAST = GAP_W'(MOVE_GAP - 1);
   localparam logic [TAP_W-1:0]   MAX_C    = TAP_W'(MAX_TAP);
   localparam logic [TAP_W-1:0]   LOAD_C   = TAP_W'(LOAD_TAP);
   localparam logic [TAP_W-1:0]   ONE_C    = TAP_W'(1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SETUP = 3'd2,
      S_MOVE  = 3'd3,
      S_GAP   = 3'd4,
      S_FIN   = 3'd5
   } state_t;

   state_t           state;
   logic [GAP_W-1:0] gap_cnt;
   logic [TAP_W-1:0] tgt;
   logic             is_load;   // current GAP belongs to a LOAD, not a MOVE

   always_ff @(posedge FAB_CLK or posedge ARST) begin
      if (ARST) begin
         state                <= S_IDLE;
         gap_cnt              <= '0;
         tgt                  <= '0;
         is_load              <= 1'b0;
         REQ_READY            <= 1'b1;
         DONE                 <= 1'b0;
         ERR                  <= 1'b0;
         CUR_TAP              <= LOAD_C;
         DELAY_LINE_MOVE      <= 1'b0;
         DELAY_LINE_DIRECTION <= 1'b0;
         DELAY_LINE_LOAD      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // REQ_READY is high throughout IDLE, so REQ_VALID alone is the handshake.
               if (REQ_VALID) begin
                  is_load   <= REQ_LOAD;
                  tgt       <= REQ_TAP;
                  ERR       <= 1'b0;
                  REQ_READY <= 1'b0;
                  if (REQ_LOAD) begin
                     DELAY_LINE_LOAD <= 1'b1;
                     state           <= S_LOAD;
                  end else if (REQ_TAP > MAX_C) begin
                     ERR   <= 1'b1;
                     DONE  <= 1'b1;
                     state <= S_FIN;
                  end else if (REQ_TAP == CUR_TAP) begin
                     DONE  <= 1'b1;
                     state <= S_FIN;
                  end else begin
                     // Registered so the IOD sees a stable direction a cycle before the first MOVE.
                     DELAY_LINE_DIRECTION <= (REQ_TAP > CUR_TAP);
                     state                <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               DELAY_LINE_MOVE <= 1'b1;
               state           <= S_MOVE;
            end
            S_MOVE: begin
               DELAY_LINE_MOVE <= 1'b0;
               CUR_TAP         <= DELAY_LINE_DIRECTION ? CUR_TAP + ONE_C : CUR_TAP - ONE_C;
               gap_cnt         <= '0;
               state           <= S_GAP;
            end
            S_LOAD: begin
               DELAY_LINE_LOAD <= 1'b0;
               gap_cnt         <= '0;
               state           <= S_GAP;
            end
            S_GAP: begin
               if (gap_cnt != GAP_LAST) begin
                  gap_cnt <= gap_cnt + GAP_W'(1);
               end else if (is_load) begin
                  CUR_TAP <= LOAD_C;
                  DONE    <= 1'b1;
                  state   <= S_FIN;
               end else if (DELAY_LINE_OUT_OF_RANGE) begin
                  // The IOD refused the last step: undo it in the tracked position.
                  CUR_TAP <= DELAY_LINE_DIRECTION ? CUR_TAP - ONE_C : CUR_TAP + ONE_C;
                  ERR     <= 1'b1;
                  DONE    <= 1'b1;
                  state   <= S_FIN;
               end else if (CUR_TAP == tgt) begin
                  DONE  <= 1'b1;
                  state <= S_FIN;
               end else begin
                  DELAY_LINE_MOVE <= 1'b1;
                  state           <= S_MOVE;
               end
            end
            S_FIN: begin
               DONE      <= 1'b0;
               REQ_READY <= 1'b1;
               state     <= S_IDLE;
            end
            default: begin
               DELAY_LINE_MOVE <= 1'b0;
               DELAY_LINE_LOAD <= 1'b0;
               DONE            <= 1'b0;
               REQ_READY       <= 1'b1;
               state           <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pf_iod_dly_tap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pf_iod_dly_tap_ctrl
// Purpose  : Directed self-checking bench for pf_iod_dly_tap_ctrl with
//            hand-computed cycle positions of MOVE/LOAD/DONE pulses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pf_iod_dly_tap_ctrl;

   logic       clk = 1'b0;
   logic       arst;
   logic       req_valid;
   logic       req_ready;
   logic       req_load;
   logic [7:0] req_tap;
   logic       done;
   logic       err;
   logic [7:0] cur_tap;
   logic       dl_move;
   logic       dl_dir;
   logic       dl_load;
   logic       dl_oor;

   int checks   = 0;
   int failures = 0;

   // Results captured by do_req (cycle 0 = handshake cycle)
   int mv_cyc [64];
   int mv_n;
   int ld_cyc;
   int ld_n;
   int done_cyc;
   int err_at_done;
   int dir_c1;
   int move_c1;
   int overlap;

   always #5 clk = ~clk;

   pf_iod_dly_tap_ctrl #(
      .TAP_W(8), .MAX_TAP(127), .LOAD_TAP(1), .MOVE_GAP(2)
   ) dut (
      .FAB_CLK                 (clk),
      .ARST                    (arst),
      .REQ_VALID               (req_valid),
      .REQ_READY               (req_ready),
      .REQ_LOAD                (req_load),
      .REQ_TAP                 (req_tap),
      .DONE                    (done),
      .ERR                     (err),
      .CUR_TAP                 (cur_tap),
      .DELAY_LINE_MOVE         (dl_move),
      .DELAY_LINE_DIRECTION    (dl_dir),
      .DELAY_LINE_LOAD         (dl_load),
      .DELAY_LINE_OUT_OF_RANGE (dl_oor)
   );

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Issues one request from a post-edge position and records pulse timing
   // until DONE. oor_after: raise OUT_OF_RANGE after that many MOVEs (0=never).
   task automatic do_req(input logic ld, input logic [7:0] tap,
                         input int oor_after, input bit busy_poke);
      mv_n = 0; ld_n = 0; ld_cyc = -1; done_cyc = -1; err_at_done = -1;
      overlap = 0;
      check("ready_before_req", int'(req_ready), 1);
      req_valid = 1'b1; req_load = ld; req_tap = tap;
      @(posedge clk); #1;
      req_valid = 1'b0; req_load = 1'b0;
      dir_c1  = int'(dl_dir);
      move_c1 = int'(dl_move);
      for (int cyc = 1; cyc <= 400; cyc++) begin
         if ((int'(dl_move) + int'(dl_load) + int'(done)) > 1) overlap++;
         if (dl_move) begin
            if (mv_n < 64) mv_cyc[mv_n] = cyc;
            mv_n++;
            if (oor_after != 0 && mv_n == oor_after) dl_oor = 1'b1;
         end
         if (dl_load) begin ld_cyc = cyc; ld_n++; end
         if (busy_poke) begin
            req_valid = (cyc == 2 || cyc == 3);
            req_tap   = 8'd50;
         end
         if (done) begin
            done_cyc    = cyc;
            err_at_done = int'(err);
            break;
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      if (done_cyc < 0) check("done_timeout", 0, 1);
      @(posedge clk); #1;
      dl_oor = 1'b0;
      check("overlap", overlap, 0);
      check("ready_after_done", int'(req_ready), 1);
   endtask

   initial begin
      arst = 1'b1; req_valid = 1'b0; req_load = 1'b0; req_tap = '0; dl_oor = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_move", int'(dl_move), 0);
      check("rst_load", int'(dl_load), 0);
      check("rst_dir",  int'(dl_dir),  0);
      check("rst_done", int'(done),    0);
      check("rst_err",  int'(err),     0);
      check("rst_cur",  int'(cur_tap), 1);
      @(negedge clk); arst = 1'b0;
      @(posedge clk); #1;
      check("rst_ready", int'(req_ready), 1);

      // 1 -> 5: four moves at 2,5,8,11; DONE at 14
      do_req(1'b0, 8'd5, 0, 1'b0);
      check("up_dir_c1", dir_c1, 1);
      check("up_setup_nomove", move_c1, 0);
      check("up_nmoves", mv_n, 4);
      for (int k = 0; k < 4; k++) check($sformatf("up_mv%0d", k), mv_cyc[k], 2 + 3*k);
      check("up_done_cyc", done_cyc, 14);
      check("up_err", err_at_done, 0);
      check("up_cur", int'(cur_tap), 5);
      check("up_dir_hold", int'(dl_dir), 1);

      // 5 -> 2: three moves down; DONE at 11
      do_req(1'b0, 8'd2, 0, 1'b0);
      check("dn_dir_c1", dir_c1, 0);
      check("dn_nmoves", mv_n, 3);
      check("dn_mv_last", mv_cyc[2], 8);
      check("dn_done_cyc", done_cyc, 11);
      check("dn_err", err_at_done, 0);
      check("dn_cur", int'(cur_tap), 2);

      // out-of-range target rejected
      do_req(1'b0, 8'd200, 0, 1'b0);
      check("rej_done_cyc", done_cyc, 1);
      check("rej_err", err_at_done, 1);
      check("rej_nmoves", mv_n, 0);
      check("rej_cur", int'(cur_tap), 2);
      check("rej_err_hold", int'(err), 1);

      // boundary: MAX_TAP itself is legal but equal-to-current is a no-op
      do_req(1'b0, 8'd2, 0, 1'b0);
      check("noop_done_cyc", done_cyc, 1);
      check("noop_err", err_at_done, 0);
      check("noop_nmoves", mv_n, 0);

      // 2 -> 1, then 1 -> 10 with range fault after 3rd move
      do_req(1'b0, 8'd1, 0, 1'b0);
      check("to1_cur", int'(cur_tap), 1);
      do_req(1'b0, 8'd10, 3, 1'b0);
      check("oor_nmoves", mv_n, 3);
      check("oor_done_cyc", done_cyc, 11);
      check("oor_err", err_at_done, 1);
      check("oor_cur", int'(cur_tap), 3);

      // 3 -> 40 (37 moves), then LOAD with ignored busy requests
      do_req(1'b0, 8'd40, 0, 1'b0);
      check("to40_nmoves", mv_n, 37);
      check("to40_done_cyc", done_cyc, 2 + 37*3);
      check("to40_cur", int'(cur_tap), 40);
      do_req(1'b1, 8'd99, 0, 1'b1);
      check("ld_cyc", ld_cyc, 1);
      check("ld_n", ld_n, 1);
      check("ld_nmoves", mv_n, 0);
      check("ld_done_cyc", done_cyc, 4);
      check("ld_err", err_at_done, 0);
      check("ld_cur", int'(cur_tap), 1);
      repeat (3) @(posedge clk);
      #1;
      check("ld_busy_ignored", int'(cur_tap), 1);

      // 1 -> 20, reset between the 2nd and 3rd MOVE
      req_valid = 1'b1; req_tap = 8'd20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      mv_n = 0;
      for (int cyc = 1; cyc <= 50 && mv_n < 2; cyc++) begin
         if (dl_move) mv_n++;
         if (mv_n < 2) begin @(posedge clk); #1; end
      end
      check("mid_saw_two_moves", mv_n, 2);
      @(posedge clk); #3;
      check("mid_pre_cur", int'(cur_tap), 3);
      arst = 1'b1;
      #1;
      check("mid_rst_move", int'(dl_move), 0);
      check("mid_rst_dir",  int'(dl_dir),  0);
      check("mid_rst_done", int'(done),    0);
      check("mid_rst_err",  int'(err),     0);
      check("mid_rst_cur",  int'(cur_tap), 1);
      @(negedge clk); arst = 1'b0;
      @(posedge clk); #1;
      check("mid_post_nomove", int'(dl_move), 0);
      do_req(1'b0, 8'd3, 0, 1'b0);
      check("post_nmoves", mv_n, 2);
      check("post_done_cyc", done_cyc, 8);
      check("post_cur", int'(cur_tap), 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
